// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl
//   APB-programmable 3-channel PWM generator with a hardware fade engine.
//   Drives the RGB0PWM/RGB1PWM/RGB2PWM inputs of an SB_RGBA_DRV LED driver.
//
// Parameters
//   PRESCALE : PWM counter advances once every PRESCALE+1 clocks (0..255)
//   W_RATE   : width of the fade-rate divisor register (1..32)
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   apbs_psel/penable/pwrite/paddr/pwdata : APB slave request
//   apbs_prdata           : combinational read data
//   apbs_pready           : always 1 (zero wait states)
//   apbs_pslverr          : always 0
//   pwm_out[2:0]          : registered PWM, [0]=R [1]=G [2]=B
//   fade_done_irq         : level, FADE_EN and DUTY==TARGET on all channels
//
// Register map (paddr[3:2])
//   0x0 CSR    : [0] EN, [1] FADE_EN, [8] DONE (read-only)
//   0x4 DUTY   : [7:0] R, [15:8] G, [23:16] B
//   0x8 TARGET : same packing as DUTY
//   0xC RATE   : [W_RATE-1:0]
module rgb_pwm_ctrl #(
  parameter int PRESCALE = 0,
  parameter int W_RATE   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apbs_psel,
  input  logic        apbs_penable,
  input  logic        apbs_pwrite,
  input  logic [15:0] apbs_paddr,
  input  logic [31:0] apbs_pwdata,
  output logic [31:0] apbs_prdata,
  output logic        apbs_pready,
  output logic        apbs_pslverr,
  output logic [2:0]  pwm_out,
  output logic        fade_done_irq
);

  localparam logic [7:0] PRE_MAX = 8'(PRESCALE);

  logic              r_en;
  logic              r_fade_en;
  logic [23:0]       r_duty;
  logic [23:0]       r_target;
  logic [W_RATE-1:0] r_rate;
  logic [W_RATE-1:0] r_fcnt;
  logic [7:0]        r_pre;
  logic [7:0]        r_cnt;
  logic [2:0]        r_pwm;

  logic              w_wr;
  logic              w_wr_csr;
  logic              w_wr_duty;
  logic              w_wr_target;
  logic              w_wr_rate;
  logic              w_step;
  logic              w_tick;
  logic              w_done;
  logic [23:0]       w_duty_step;
  logic [2:0]        w_pwm_next;
  logic              w_unused;

  assign apbs_pready   = 1'b1;
  assign apbs_pslverr  = 1'b0;
  assign pwm_out       = r_pwm;
  assign fade_done_irq = w_done;

  // Address bits outside [3:2] are ignored by design.
  assign w_unused = &{1'b0, apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata};

  always_comb begin
    w_wr        = apbs_psel & apbs_penable & apbs_pwrite;
    w_wr_csr    = w_wr & (apbs_paddr[3:2] == 2'd0);
    w_wr_duty   = w_wr & (apbs_paddr[3:2] == 2'd1);
    w_wr_target = w_wr & (apbs_paddr[3:2] == 2'd2);
    w_wr_rate   = w_wr & (apbs_paddr[3:2] == 2'd3);
    w_step      = (r_pre == PRE_MAX);
    w_tick      = r_fade_en & (r_fcnt == r_rate);
    w_done      = r_fade_en & (r_duty == r_target);
  end

  // One-step move of every channel toward its target; channels already at
  // target keep their value, so the ramp can never overshoot.
  always_comb begin
    w_duty_step = r_duty;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_duty[8*i +: 8] < r_target[8*i +: 8])
        w_duty_step[8*i +: 8] = r_duty[8*i +: 8] + 8'd1;
      else if (r_duty[8*i +: 8] > r_target[8*i +: 8])
        w_duty_step[8*i +: 8] = r_duty[8*i +: 8] - 8'd1;
    end
  end

  always_comb begin
    w_pwm_next = '0;
    for (int unsigned i = 0; i < 3; i++)
      w_pwm_next[i] = r_en & (r_cnt < r_duty[8*i +: 8]);
  end

  always_comb begin
    apbs_prdata = '0;
    case (apbs_paddr[3:2])
      2'd0:    apbs_prdata = {23'd0, w_done, 6'd0, r_fade_en, r_en};
      2'd1:    apbs_prdata = {8'd0, r_duty};
      2'd2:    apbs_prdata = {8'd0, r_target};
      default: apbs_prdata = 32'(r_rate);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_fade_en <= 1'b0;
      r_target  <= '0;
      r_rate    <= '0;
    end else begin
      if (w_wr_csr) begin
        r_en      <= apbs_pwdata[0];
        r_fade_en <= apbs_pwdata[1];
      end
      if (w_wr_target) r_target <= apbs_pwdata[23:0];
      if (w_wr_rate)   r_rate   <= apbs_pwdata[W_RATE-1:0];
    end
  end

  // A software DUTY write takes priority over a coincident fade tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_duty <= '0;
    else if (w_wr_duty)
      r_duty <= apbs_pwdata[23:0];
    else if (w_tick)
      r_duty <= w_duty_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      if (w_step) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_pre <= r_pre + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fcnt <= '0;
    else if (!r_fade_en || w_wr_rate || w_tick)
      r_fcnt <= '0;
    else
      r_fcnt <= r_fcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pwm <= '0;
    else
      r_pwm <= w_pwm_next;
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
module tb_rgb_pwm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        apbs_psel;
  logic        apbs_penable;
  logic        apbs_pwrite;
  logic [15:0] apbs_paddr;
  logic [31:0] apbs_pwdata;
  logic [31:0] apbs_prdata;
  logic        apbs_pready;
  logic        apbs_pslverr;
  logic [2:0]  pwm_out;
  logic        fade_done_irq;

  int n_cmp;
  int n_err;
  int cyc;

  rgb_pwm_ctrl #(
    .PRESCALE(0),
    .W_RATE(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .apbs_psel(apbs_psel),
    .apbs_penable(apbs_penable),
    .apbs_pwrite(apbs_pwrite),
    .apbs_paddr(apbs_paddr),
    .apbs_pwdata(apbs_pwdata),
    .apbs_prdata(apbs_prdata),
    .apbs_pready(apbs_pready),
    .apbs_pslverr(apbs_pslverr),
    .pwm_out(pwm_out),
    .fade_done_irq(fade_done_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Write commits on the posedge between the 2nd and 3rd negedge; returns
  // on the negedge right after the commit edge.
  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    apbs_paddr   = a;
    apbs_pwdata  = d;
    apbs_psel    = 1'b1;
    apbs_pwrite  = 1'b1;
    apbs_penable = 1'b0;
    @(negedge clk);
    apbs_penable = 1'b1;
    @(negedge clk);
    apbs_psel    = 1'b0;
    apbs_penable = 1'b0;
    apbs_pwrite  = 1'b0;
  endtask

  // Combinational read, consumes no clock edge.
  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    apbs_paddr  = a;
    apbs_psel   = 1'b1;
    apbs_pwrite = 1'b0;
    #1;
    d = apbs_prdata;
    apbs_psel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int bad;
    rst_n        = 1'b0;
    apbs_psel    = 1'b0;
    apbs_penable = 1'b0;
    apbs_pwrite  = 1'b0;
    apbs_paddr   = '0;
    apbs_pwdata  = '0;
    #1;
    n_cmp++;
    if (pwm_out !== 3'b000) begin
      n_err++;
      $display("FAIL reset_pwm: got %b expected 000", pwm_out);
    end
    n_cmp++;
    if (fade_done_irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b expected 0", fade_done_irq);
    end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pwm_out !== 3'b000) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL idle_pwm: got %0d high samples expected 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(16'(i * 4), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h expected 00000000", i, d);
      end
    end
    n_cmp++;
    if (apbs_pready !== 1'b1 || apbs_pslverr !== 1'b0) begin
      n_err++;
      $display("FAIL ready_slverr: got %b%b expected 10", apbs_pready, apbs_pslverr);
    end
  endtask

  task automatic test_duty_sweep();
    logic [31:0] d;
    int hr, hg, hb;
    apb_write(16'h4, 32'h00FF4000);
    apb_write(16'h0, 32'h1);
    repeat (2) @(negedge clk);
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out[0] === 1'b1) hr++;
      if (pwm_out[1] === 1'b1) hg++;
      if (pwm_out[2] === 1'b1) hb++;
    end
    n_cmp++;
    if (hr !== 0) begin
      n_err++;
      $display("FAIL sweep_r: got %0d expected 0", hr);
    end
    n_cmp++;
    if (hg !== 64) begin
      n_err++;
      $display("FAIL sweep_g: got %0d expected 64", hg);
    end
    n_cmp++;
    if (hb !== 255) begin
      n_err++;
      $display("FAIL sweep_b: got %0d expected 255", hb);
    end
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h00FF4000) begin
      n_err++;
      $display("FAIL sweep_duty_rd: got %h expected 00ff4000", d);
    end
  endtask

  task automatic test_en_toggle();
    logic prev;
    int f0, f1, bad;
    logic found;
    // Locate a G falling edge (cnt crossing 64) as phase reference.
    found = 1'b0; f0 = 0;
    prev = pwm_out[1];
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && pwm_out[1] === 1'b0) begin
        found = 1'b1;
        f0 = cyc;
      end
      prev = pwm_out[1];
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL en_ref_edge: got timeout expected G falling edge");
    end
    apb_write(16'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (pwm_out !== 3'b000) begin
      n_err++;
      $display("FAIL en_off: got %b expected 000", pwm_out);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out !== 3'b000) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL en_off_hold: got %0d high samples expected 0", bad);
    end
    apb_write(16'h0, 32'h1);
    found = 1'b0; f1 = 0;
    prev = pwm_out[1];
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && pwm_out[1] === 1'b0) begin
        found = 1'b1;
        f1 = cyc;
      end
      prev = pwm_out[1];
    end
    n_cmp++;
    if (!found || ((f1 - f0) % 256) != 0) begin
      n_err++;
      $display("FAIL en_phase: got offset %0d (found=%b) expected 0 mod 256", f1 - f0, found);
    end
  endtask

  task automatic test_fade();
    logic [31:0] d;
    apb_write(16'hC, 32'h3);
    apb_write(16'h4, 32'h000A0000);
    apb_write(16'h8, 32'h0000000A);
    apb_write(16'h0, 32'h3);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h000A0000) begin
      n_err++;
      $display("FAIL fade_t0: got %h expected 000a0000", d);
    end
    repeat (4) @(negedge clk);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h00090001) begin
      n_err++;
      $display("FAIL fade_t1: got %h expected 00090001", d);
    end
    repeat (32) @(negedge clk);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h00010009) begin
      n_err++;
      $display("FAIL fade_t9: got %h expected 00010009", d);
    end
    n_cmp++;
    if (fade_done_irq !== 1'b0) begin
      n_err++;
      $display("FAIL fade_irq_early: got %b expected 0", fade_done_irq);
    end
    repeat (4) @(negedge clk);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h0000000A) begin
      n_err++;
      $display("FAIL fade_t10: got %h expected 0000000a", d);
    end
    n_cmp++;
    if (fade_done_irq !== 1'b1) begin
      n_err++;
      $display("FAIL fade_irq: got %b expected 1", fade_done_irq);
    end
    apb_read(16'h0, d);
    n_cmp++;
    if (d !== 32'h00000103) begin
      n_err++;
      $display("FAIL fade_csr: got %h expected 00000103", d);
    end
    repeat (8) @(negedge clk);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h0000000A) begin
      n_err++;
      $display("FAIL fade_hold: got %h expected 0000000a", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    apb_write(16'h8, 32'h00000060);
    // RATE write restarts fcnt, so the 4th edge after it is a tick; the
    // DUTY write below is timed to commit on exactly that edge.
    apb_write(16'hC, 32'h3);
    @(negedge clk);
    apb_write(16'h4, 32'h00000050);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h00000050) begin
      n_err++;
      $display("FAIL coll_write_wins: got %h expected 00000050", d);
    end
    n_cmp++;
    if (fade_done_irq !== 1'b0) begin
      n_err++;
      $display("FAIL coll_irq: got %b expected 0", fade_done_irq);
    end
    repeat (3) @(negedge clk);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h00000050) begin
      n_err++;
      $display("FAIL coll_pre_tick: got %h expected 00000050", d);
    end
    @(negedge clk);
    apb_read(16'h4, d);
    n_cmp++;
    if (d !== 32'h00000051) begin
      n_err++;
      $display("FAIL coll_next_tick: got %h expected 00000051", d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic found;
    apb_write(16'h4, 32'h00000030);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (pwm_out[0] === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL arst_wait_high: got timeout expected R high");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pwm_out !== 3'b000) begin
      n_err++;
      $display("FAIL arst_pwm: got %b expected 000", pwm_out);
    end
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apb_read(16'(i * 4), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++;
        $display("FAIL arst_reg%0d: got %h expected 00000000", i, d);
      end
    end
    n_cmp++;
    if (fade_done_irq !== 1'b0) begin
      n_err++;
      $display("FAIL arst_irq: got %b expected 0", fade_done_irq);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_duty_sweep();
    test_en_toggle();
    test_fade();
    test_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
